// File: rtl/xor_pkg.sv
// Shared types and defaults for the round-robin arbitrated XOR datapath.
// The operand struct is sized by DATA_W_DEF; instances must keep DATA_W equal to it.
package xor_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a_in;
    logic [DATA_W_DEF-1:0] b_in;
  } struct_port;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [DATA_W_DEF-1:0] xor_pair(input struct_port p);
    return p.a_in ^ p.b_in;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first set bit of req at or above ptr, wrapping around.
// Produces a one-hot grant and its encoded index; both are zero when req is zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   k;
  logic found;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!found && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_arb_ctrl.sv
// NUM_REQ requesters share one XOR datapath through a round-robin arbiter
// feeding a single result register with valid/ready handshake on both sides.
module xor_arb_ctrl
  import xor_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  struct_port [NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic [15:0]             op_count
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [15:0]       op_count_q, op_count_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               can_accept;
  logic               accept;
  logic               consume;
  struct_port         sel_pair;
  logic [DATA_W-1:0]  xor_result;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The slot frees up in the same cycle the consumer drains it, which is what
  // gives one result per cycle under continuous demand.
  assign can_accept = rst_n && ((state_q == ST_IDLE) || out_ready);
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;
  assign consume    = (state_q == ST_HOLD) && out_ready;

  assign sel_pair   = req_data[grant_idx];
  assign xor_result = xor_pair(sel_pair);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    op_count_d = op_count_q;

    if (consume && (op_count_q != OP_COUNT_MAX)) begin
      op_count_d = op_count_q + 16'd1;
    end

    if (accept) begin
      state_d    = ST_HOLD;
      out_data_d = xor_result;
      out_id_d   = grant_idx;
      rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (consume) begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: the result register is reset too, so out_data/out_id read zero
  // after reset rather than a stale operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign op_count  = op_count_q;

endmodule
